// File: rtl/instr_encoder_if.sv
// Request channel (symbolic instruction in) and imem write channel of instr_encoder.
// The slave modport is the encoder's view. The master modport is the environment's view.
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [2:0]        in_funct3;
    logic              in_f7b5;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ready;

    modport master (
        output in_valid, in_kind, in_funct3, in_f7b5, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready,
        input  imem_we, imem_addr, imem_wdata,
        output imem_ready
    );

    modport slave (
        input  in_valid, in_kind, in_funct3, in_f7b5, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready,
        output imem_we, imem_addr, imem_wdata,
        input  imem_ready
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I encoder for lw/sw/R/beq/I-ALU/jal requests. It streams the encoded words into
// imem at consecutive word addresses through a one-entry output register.
module instr_encoder #(
    parameter int ADDR_W = 8,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    instr_encoder_if.slave    bus,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic              full
);
    localparam int              DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

    localparam logic [2:0] K_LW   = 3'd0;
    localparam logic [2:0] K_SW   = 3'd1;
    localparam logic [2:0] K_R    = 3'd2;
    localparam logic [2:0] K_BEQ  = 3'd3;
    localparam logic [2:0] K_IALU = 3'd4;
    localparam logic [2:0] K_JAL  = 3'd5;

    function automatic logic [31:0] enc_word(
        input logic [2:0]         kind,
        input logic [2:0]         f3,
        input logic               f7b5,
        input logic [4:0]         rd,
        input logic [4:0]         rs1,
        input logic [4:0]         rs2,
        input logic signed [31:0] imm
    );
        logic [31:0] w;
        w = '0;
        case (kind)
            K_LW:   w = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            K_SW:   w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            K_R:    w = {1'b0, f7b5, 5'b00000, rs2, rs1, f3, rd, 7'b0110011};
            K_BEQ:  w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
            K_IALU: w = {imm[11:0], rs1, f3, rd, 7'b0010011};
            K_JAL:  w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            default: w = '0;
        endcase
        return w;
    endfunction

    // Kinds 6/7 and out-of-range or odd branch/jump offsets are rejected here.
    function automatic logic imm_legal(
        input logic [2:0]         kind,
        input logic signed [31:0] imm
    );
        logic ok;
        ok = 1'b0;
        case (kind)
            K_LW, K_SW, K_IALU: ok = (imm >= -32'sd2048) && (imm <= 32'sd2047);
            K_R:                ok = 1'b1;
            K_BEQ:              ok = (imm >= -32'sd4096) && (imm <= 32'sd4094) && !imm[0];
            K_JAL:              ok = (imm >= -32'sd1048576) && (imm <= 32'sd1048574) && !imm[0];
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic signed [31:0] imm_p0;
    logic [31:0]        word_p0;
    logic               legal_p0;
    logic               accept_p0;
    logic [ADDR_W+1:0]  occupancy;

    logic [31:0]        word_p1;
    logic               vld_p1;
    logic [ADDR_W-1:0]  ptr;
    logic               wr_done;

    // Stage p0: combinational encode of the request on the bus
    assign imm_p0   = $signed(bus.in_imm);
    assign word_p0  = enc_word(bus.in_kind, bus.in_funct3, bus.in_f7b5,
                               bus.in_rd, bus.in_rs1, bus.in_rs2, imm_p0);
    assign legal_p0 = imm_legal(bus.in_kind, imm_p0);

    // Words already counted plus the one still pending must leave room for another.
    assign occupancy = {1'b0, count} + {{(ADDR_W+1){1'b0}}, vld_p1};
    assign full      = (count == (ADDR_W+1)'(DEPTH));
    assign wr_done   = vld_p1 && bus.imem_ready;

    assign bus.in_ready = rst_n && !start && !full
                          && (occupancy < (ADDR_W+2)'(DEPTH))
                          && (!vld_p1 || bus.imem_ready);
    assign accept_p0    = bus.in_valid && bus.in_ready;

    // Stage p1: output word register driving the imem write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            word_p1 <= '0;
            ptr     <= BASE_A;
            count   <= '0;
            err     <= 1'b0;
        end else if (start) begin
            vld_p1 <= 1'b0;
            ptr    <= BASE_A;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (wr_done) begin
                ptr   <= ptr + 1'b1;
                count <= count + 1'b1;
            end
            if (accept_p0 && legal_p0) begin
                vld_p1  <= 1'b1;
                word_p1 <= word_p0;
            end else if (wr_done) begin
                vld_p1 <= 1'b0;
            end
            if (accept_p0 && !legal_p0)
                err <= 1'b1;
        end
    end

    assign bus.imem_we    = vld_p1;
    assign bus.imem_addr  = ptr;
    assign bus.imem_wdata = word_p1;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-depth instance and a 4-word instance
// share the request fields and use separate valid, ready and reset signals.
module tb_instr_encoder;
    logic       clk = 1'b0;
    logic       rst_n, rst_n_s;
    logic       start, start_s;
    logic [8:0] count0;
    logic [2:0] count1;
    logic       err0, err1, full0, full1;

    logic [2:0]  r_kind, r_f3;
    logic        r_f7b5;
    logic [4:0]  r_rd, r_rs1, r_rs2;
    logic [31:0] r_imm;

    int checks = 0;
    int errors = 0;

    instr_encoder_if #(.ADDR_W(8)) i0 ();
    instr_encoder_if #(.ADDR_W(2)) i1 ();

    assign i0.in_kind = r_kind;  assign i0.in_funct3 = r_f3;  assign i0.in_f7b5 = r_f7b5;
    assign i0.in_rd   = r_rd;    assign i0.in_rs1    = r_rs1; assign i0.in_rs2  = r_rs2;
    assign i0.in_imm  = r_imm;
    assign i1.in_kind = r_kind;  assign i1.in_funct3 = r_f3;  assign i1.in_f7b5 = r_f7b5;
    assign i1.in_rd   = r_rd;    assign i1.in_rs1    = r_rs1; assign i1.in_rs2  = r_rs2;
    assign i1.in_imm  = r_imm;

    instr_encoder #(.ADDR_W(8), .BASE(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(i0.slave),
        .count(count0), .err(err0), .full(full0)
    );

    instr_encoder #(.ADDR_W(2), .BASE(0)) dut_s (
        .clk(clk), .rst_n(rst_n_s), .start(start_s), .bus(i1.slave),
        .count(count1), .err(err1), .full(full1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [2:0] kind, input logic [2:0] f3, input logic f7b5,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm);
        r_kind = kind; r_f3 = f3; r_f7b5 = f7b5;
        r_rd = rd; r_rs1 = rs1; r_rs2 = rs2; r_imm = imm;
    endtask

    // One request on the wide instance, accepted at the next edge; returns at the following negedge.
    task automatic one_req(input logic [2:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
        @(posedge clk); #1;
        set_req(kind, 3'd0, 1'b0, rd, rs1, rs2, imm);
        i0.in_valid = 1'b1;
        @(posedge clk); #1;
        i0.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; rst_n_s = 1'b0; start = 1'b0; start_s = 1'b0;
        i0.in_valid = 1'b0; i1.in_valid = 1'b0;
        i0.imem_ready = 1'b1; i1.imem_ready = 1'b1;
        set_req(3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);

        repeat (2) @(negedge clk);
        chk("rst_we",    i0.imem_we, 0);
        chk("rst_addr",  i0.imem_addr, 0);
        chk("rst_wdata", i0.imem_wdata, 0);
        chk("rst_count", count0, 0);
        chk("rst_err",   err0, 0);
        chk("rst_full",  full0, 0);
        chk("rst_ready", i0.in_ready, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // addi x1, x0, 5
        set_req(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        i0.in_valid = 1'b1;
        @(negedge clk);
        chk("t1_ready", i0.in_ready, 1);
        @(posedge clk); #1 i0.in_valid = 1'b0;
        @(negedge clk);
        chk("t1_we",    i0.imem_we, 1);
        chk("t1_addr",  i0.imem_addr, 0);
        chk("t1_wdata", i0.imem_wdata, 32'h00500093);
        chk("t1_cnt0",  count0, 0);
        @(negedge clk);
        chk("t1_we_off", i0.imem_we, 0);
        chk("t1_cnt1",   count0, 1);
        chk("t1_addr1",  i0.imem_addr, 1);

        // lw / sw back to back from BASE
        pulse_start;
        chk("st_count", count0, 0);
        chk("st_addr",  i0.imem_addr, 0);
        @(posedge clk); #1;
        set_req(3'd0, 3'd0, 1'b0, 5'd2, 5'd1, 5'd0, 32'd8);
        i0.in_valid = 1'b1;
        @(posedge clk); #1;
        set_req(3'd1, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4);
        @(negedge clk);
        chk("lw_addr",  i0.imem_addr, 0);
        chk("lw_wdata", i0.imem_wdata, 32'h0080A103);
        chk("lw_ready", i0.in_ready, 1);
        @(posedge clk); #1 i0.in_valid = 1'b0;
        @(negedge clk);
        chk("sw_we",    i0.imem_we, 1);
        chk("sw_addr",  i0.imem_addr, 1);
        chk("sw_wdata", i0.imem_wdata, 32'h0020A223);
        chk("sw_cnt",   count0, 1);
        @(negedge clk);
        chk("lwsw_cnt", count0, 2);

        // R-type add, beq -4, jal 8 streamed back to back
        @(posedge clk); #1;
        set_req(3'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
        i0.in_valid = 1'b1;
        @(posedge clk); #1;
        set_req(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4);
        @(negedge clk);
        chk("r_wdata", i0.imem_wdata, 32'h002081B3);
        chk("r_addr",  i0.imem_addr, 2);
        @(posedge clk); #1;
        set_req(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
        @(negedge clk);
        chk("beq_wdata", i0.imem_wdata, 32'hFE208EE3);
        chk("beq_addr",  i0.imem_addr, 3);
        @(posedge clk); #1 i0.in_valid = 1'b0;
        @(negedge clk);
        chk("jal_wdata", i0.imem_wdata, 32'h008000EF);
        chk("jal_addr",  i0.imem_addr, 4);
        @(negedge clk);
        chk("rbj_cnt", count0, 5);
        chk("rbj_we",  i0.imem_we, 0);

        // imem backpressure: imm 2047 pending, imm -2048 waiting
        @(posedge clk); #1;
        i0.imem_ready = 1'b0;
        set_req(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2047);
        i0.in_valid = 1'b1;
        @(posedge clk); #1;
        set_req(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, -32'sd2048);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_we",    i0.imem_we, 1);
            chk("stall_addr",  i0.imem_addr, 5);
            chk("stall_wdata", i0.imem_wdata, 32'h7FF00093);
            chk("stall_ready", i0.in_ready, 0);
            chk("stall_cnt",   count0, 5);
        end
        @(posedge clk); #1 i0.imem_ready = 1'b1;
        @(negedge clk);
        chk("unstall_ready", i0.in_ready, 1);
        chk("unstall_cnt",   count0, 5);
        @(posedge clk); #1 i0.in_valid = 1'b0;
        @(negedge clk);
        chk("neg_cnt",   count0, 6);
        chk("neg_addr",  i0.imem_addr, 6);
        chk("neg_wdata", i0.imem_wdata, 32'h80000093);
        @(negedge clk);
        chk("neg_done", count0, 7);

        // illegal requests are consumed without writes
        pulse_start;
        one_req(3'd3, 5'd0, 5'd1, 5'd2, 32'd3);
        chk("odd_beq_we",  i0.imem_we, 0);
        chk("odd_beq_err", err0, 1);
        chk("odd_beq_cnt", count0, 0);
        one_req(3'd4, 5'd1, 5'd0, 5'd0, 32'd4096);
        chk("big_imm_we",    i0.imem_we, 0);
        chk("big_imm_ready", i0.in_ready, 1);
        one_req(3'd6, 5'd1, 5'd0, 5'd0, 32'd0);
        chk("kind6_we",  i0.imem_we, 0);
        chk("kind6_cnt", count0, 0);
        chk("kind6_err", err0, 1);
        pulse_start;
        chk("start_err", err0, 0);
        one_req(3'd4, 5'd1, 5'd0, 5'd0, 32'd4096);
        chk("big_imm_err", err0, 1);
        pulse_start;
        one_req(3'd7, 5'd1, 5'd0, 5'd0, 32'd0);
        chk("kind7_err", err0, 1);
        pulse_start;
        one_req(3'd0, 5'd1, 5'd0, 5'd0, -32'sd2049);
        chk("lw_low_err", err0, 1);
        pulse_start;
        one_req(3'd5, 5'd0, 5'd0, 5'd0, 32'h00100000);
        chk("jal_big_err", err0, 1);
        chk("jal_big_we",  i0.imem_we, 0);
        pulse_start;
        one_req(3'd3, 5'd0, 5'd0, 5'd0, 32'd4094);
        chk("beq_max_err",   err0, 0);
        chk("beq_max_wdata", i0.imem_wdata, 32'h7E000FE3);
        @(negedge clk);
        one_req(3'd5, 5'd0, 5'd0, 5'd0, 32'h000FFFFE);
        chk("jal_max_err",   err0, 0);
        chk("jal_max_wdata", i0.imem_wdata, 32'h7FFFF06F);
        chk("jal_max_addr",  i0.imem_addr, 1);
        @(negedge clk);
        chk("max_cnt", count0, 2);

        // start beats a same-cycle request
        @(posedge clk); #1;
        start = 1'b1;
        set_req(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
        i0.in_valid = 1'b1;
        @(negedge clk);
        chk("st_req_ready", i0.in_ready, 0);
        @(posedge clk); #1;
        start = 1'b0; i0.in_valid = 1'b0;
        @(negedge clk);
        chk("st_req_we",  i0.imem_we, 0);
        chk("st_req_cnt", count0, 0);

        // start discards a stalled pending word
        i0.imem_ready = 1'b0;
        one_req(3'd4, 5'd1, 5'd0, 5'd0, 32'd9);
        chk("pend_we", i0.imem_we, 1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; i0.imem_ready = 1'b1;
        @(negedge clk);
        chk("disc_we",   i0.imem_we, 0);
        chk("disc_cnt",  count0, 0);
        chk("disc_addr", i0.imem_addr, 0);

        // 4-word instance: fill, stall, then async reset mid-stall
        @(posedge clk); #1 rst_n_s = 1'b1;
        i1.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'(i + 1));
            @(posedge clk); #1;
        end
        set_req(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd99);
        @(negedge clk);
        chk("s_last_wdata", i1.imem_wdata, 32'h00400093);
        chk("s_last_cnt",   count1, 3);
        chk("s_last_ready", i1.in_ready, 0);
        @(negedge clk);
        chk("s_full",  full1, 1);
        chk("s_cnt4",  count1, 4);
        chk("s_ready", i1.in_ready, 0);
        chk("s_we",    i1.imem_we, 0);
        repeat (2) begin
            @(negedge clk);
            chk("s_stall_cnt",   count1, 4);
            chk("s_stall_ready", i1.in_ready, 0);
        end
        @(posedge clk); #1 rst_n_s = 1'b0;
        #1;
        chk("s_rst_cnt",   count1, 0);
        chk("s_rst_full",  full1, 0);
        chk("s_rst_addr",  i1.imem_addr, 0);
        chk("s_rst_ready", i1.in_ready, 0);
        i1.in_valid = 1'b0;
        @(posedge clk); #1 rst_n_s = 1'b1;
        @(negedge clk);
        chk("s_after_ready", i1.in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Inverse of the main control decoder: accepts symbolic instruction requests (class, registers, immediate) over a valid/ready handshake, encodes them into 32-bit RV32I machine words, and streams them into the instruction-memory write port at consecutive word addresses. It covers the same instruction set the core decodes: lw, sw, R-type ALU, beq, I-type ALU, jal. It sits in the test/boot path in front of imem and loads programs without an external assembler.

## Interface
- ADDR_W, 8, imem word-address width; depth DEPTH = 2^ADDR_W
- BASE, 0, first word address written after reset or start
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse: flush pending word, pointer := BASE, count := 0, err := 0
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept a request this cycle
- in_kind  input  3  0 lw, 1 sw, 2 R-type, 3 beq, 4 I-ALU, 5 jal, 6/7 illegal
- in_funct3  input  3  funct3 for R-type and I-ALU (ignored otherwise)
- in_f7b5  input  1  funct7[5] for R-type (sub/sra); ignored otherwise
- in_rd, in_rs1, in_rs2  input  5 each  register fields
- in_imm  input  32  signed byte-offset/immediate
- imem_we  output  1  write strobe (word pending)
- imem_addr  output  ADDR_W  word address
- imem_wdata  output  32  encoded instruction
- imem_ready  input  1  imem accepts write this cycle
- count  output  ADDR_W+1  words written since reset/start
- err  output  1  sticky: illegal kind or immediate out of range
- full  output  1  count == DEPTH

## Operation
- Handshake: request transfers when in_valid && in_ready. in_ready = !start && !full && (count + imem_we < DEPTH) && (!imem_we || imem_ready).
- Accepted legal request is encoded combinationally and registered into the output word register; imem_we := 1.
- Write completes when imem_we && imem_ready: pointer += 1 (wraps mod DEPTH, unreachable beyond full), count += 1; imem_we drops unless a new request is accepted the same cycle.
- Encodings (opcode in [6:0]):
  - lw: imm[11:0] rs1 010 rd 0000011
  - sw: imm[11:5] rs2 rs1 010 imm[4:0] 0100011
  - R: 0 f7b5 00000 rs2 rs1 funct3 rd 0110011
  - beq: imm[12] imm[10:5] rs2 rs1 000 imm[4:1] imm[11] 1100011
  - I-ALU: imm[11:0] rs1 funct3 rd 0010011
  - jal: imm[20] imm[10:1] imm[11] imm[19:12] rd 1101111
- Range checks: lw/sw/I-ALU need −2048..2047; beq needs −4096..4094 and even; jal needs −2^20..2^20−2 and even.
- Illegal kind or failed range check: request is accepted (consumed), nothing written, err := 1, count unchanged.

## Timing
- Reset (async, rst_n low): in_ready 0 while held; imem_we 0, imem_addr BASE, imem_wdata 0, count 0, err 0, full 0.
- Latency: accept at edge N → imem_we high during cycle N+1; with imem_ready high, one word per cycle sustained.
- imem_ready low: imem_we, imem_addr, imem_wdata held stable; in_ready 0.
- start with in_valid same cycle: start wins, request not accepted. start with pending write: word discarded, no write counted.
- Reaching DEPTH words: full 1, in_ready 0 until start or reset.
- rst_n asserted mid-write: pending word lost, all outputs to reset values immediately.

## Test plan
- I-ALU funct3 0, rd 1, rs1 0, imm 5 → imem_wdata 0x00500093 at addr BASE one cycle after accept; count 1.
- lw rd2 rs1 1 imm 8, then sw rs2 2 rs1 1 imm 4 back-to-back, imem_ready tied high → 0x0080A103 at addr 0, 0x0020A223 at addr 1 on consecutive cycles.
- R-type funct3 0, f7b5 0, rd3 rs1 1 rs2 2 → 0x002081B3; beq rs1 1 rs2 2 imm −4 → 0xFE208EE3; jal rd1 imm 8 → 0x008000EF.
- imem_ready low 3 cycles with a word pending → imem_we/addr/wdata stable, in_ready 0, count unchanged; write lands on the first ready cycle.
- beq imm 3, then I-ALU imm 4096, then kind 6 → no writes, err 1 after the first, count 0; start pulse → err 0.
- ADDR_W=2: write 4 words → full 1, in_ready 0; 5th request stalls; rst_n pulse low mid-stall → count 0, full 0, imem_addr BASE.
